// File: rtl/firebird7_in_gate2_occ_seq_pkg.sv
// Shared types and helpers for the gate2 OCC capture-pulse sequencer.
// State encoding, pattern length limit and the length clamp.
package firebird7_in_gate2_occ_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CAPTURE,
    UNLOAD,
    DONE
  } state_t;

  localparam int unsigned MAX_PATTERN_LEN = 4;

  // OCC capture_cycle_width codes 5..7 behave like 4
  function automatic logic [2:0] clamp_len(input logic [2:0] len);
    if (len > 3'(MAX_PATTERN_LEN))
      return 3'(MAX_PATTERN_LEN);
    return len;
  endfunction

endpackage

// File: rtl/firebird7_in_gate2_occ_seq_cnt.sv
// Loadable saturating down counter with a zero flag.
// Shared by the bit counter and the guard/capture wait counter.
module firebird7_in_gate2_occ_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (dec && (count != '0))
      count <= count - W'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/firebird7_in_gate2_occ_capture_seq.sv
// Capture-pulse sequencer driving the gate2 OCC scan_en/scan_in pins.
// Define FIREBIRD7_OCC_SEQ_READBACK_EN to add the scan_out flush check.
module firebird7_in_gate2_occ_capture_seq
  import firebird7_in_gate2_occ_seq_pkg::*;
#(
  parameter int GUARD_CYCLES = 2,
  parameter int WAIT_W       = 8
) (
  input  logic              slow_clock,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        pattern,
  input  logic [2:0]        pattern_len,
  input  logic [WAIT_W-1:0] capture_wait,
  input  logic              occ_scan_out,
  output logic              scan_en,
  output logic              scan_in,
  output logic              busy,
`ifdef FIREBIRD7_OCC_SEQ_READBACK_EN
  output logic              done,
  output logic              readback_err
`else
  output logic              done
`endif
);

  state_t state, state_n;

  logic [4:0]        pat_q, pat_n;
  logic [2:0]        len_q, len_n;
  logic [WAIT_W-1:0] wait_q, wait_n;

  logic              bit_load, bit_dec, bit_zero;
  logic [2:0]        bit_val, bit_cnt;
  logic              wt_load, wt_dec, wt_zero;
  logic [WAIT_W-1:0] wt_val, wt_cnt;

  logic scan_en_n, scan_in_n, busy_n, done_n;

  firebird7_in_gate2_occ_seq_cnt #(.W(3)) u_bit_cnt (
    .clk   (slow_clock),
    .reset (reset),
    .load  (bit_load),
    .value (bit_val),
    .dec   (bit_dec),
    .count (bit_cnt),
    .zero  (bit_zero)
  );

  firebird7_in_gate2_occ_seq_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk   (slow_clock),
    .reset (reset),
    .load  (wt_load),
    .value (wt_val),
    .dec   (wt_dec),
    .count (wt_cnt),
    .zero  (wt_zero)
  );

  always_ff @(posedge slow_clock) begin
    if (!reset) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      scan_en <= 1'b0;
      scan_in <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      pat_q   <= pat_n;
      len_q   <= len_n;
      wait_q  <= wait_n;
      scan_en <= scan_en_n;
      scan_in <= scan_in_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    len_n     = len_q;
    wait_n    = wait_q;
    bit_load  = 1'b0;
    bit_val   = len_q;
    bit_dec   = 1'b0;
    wt_load   = 1'b0;
    wt_val    = wait_q;
    wt_dec    = 1'b0;
    scan_in_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n   = LOAD;
          len_n     = clamp_len(pattern_len);
          wait_n    = capture_wait;
          pat_n     = {1'b0, pattern[4:1]};
          bit_load  = 1'b1;
          bit_val   = clamp_len(pattern_len);
          scan_in_n = pattern[0];
        end
      end
      LOAD: begin
        if (bit_zero) begin
          state_n = SETTLE;
          wt_load = 1'b1;
          wt_val  = WAIT_W'(GUARD_CYCLES - 1);
        end else begin
          bit_dec   = 1'b1;
          scan_in_n = pat_q[0];
          pat_n     = {1'b0, pat_q[4:1]};
        end
      end
      SETTLE: begin
        if (wt_zero) begin
          state_n = CAPTURE;
          wt_load = 1'b1;
          wt_val  = wait_q;
        end else begin
          wt_dec = 1'b1;
        end
      end
      CAPTURE: begin
        if (wt_zero) begin
          state_n  = UNLOAD;
          bit_load = 1'b1;
          bit_val  = len_q;
        end else begin
          wt_dec = 1'b1;
        end
      end
      UNLOAD: begin
        if (bit_zero)
          state_n = DONE;
        else
          bit_dec = 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    scan_en_n = (state_n == LOAD) || (state_n == UNLOAD);
    busy_n    = (state_n == LOAD) || (state_n == SETTLE) ||
                (state_n == CAPTURE) || (state_n == UNLOAD);
    done_n    = (state_n == DONE);
  end

`ifdef FIREBIRD7_OCC_SEQ_READBACK_EN
  // DONE is sampled too since the OCC retimes scan_out on the falling edge
  always_ff @(posedge slow_clock) begin
    if (!reset)
      readback_err <= 1'b0;
    else if ((state == IDLE) && start)
      readback_err <= 1'b0;
    else if (((state == UNLOAD) || (state == DONE)) && occ_scan_out)
      readback_err <= 1'b1;
  end
`else
  logic unused_scan_out;
  assign unused_scan_out = occ_scan_out;
`endif

endmodule

// File: tb/tb_firebird7_in_gate2_occ_capture_seq.sv
// Directed bench for the gate2 OCC capture-pulse sequencer.
// Covers FIREBIRD7_OCC_SEQ_READBACK_EN when that macro is defined.
module tb_firebird7_in_gate2_occ_capture_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [4:0] pattern;
  logic [2:0] pattern_len;
  logic [7:0] capture_wait;
  logic       occ_scan_out;
  logic       scan_en, scan_in, busy, done;
  logic       readback_err;

  int errors = 0;
  int checks = 0;

  logic tr_en[1024];
  logic tr_in[1024];
  logic tr_busy[1024];
  logic tr_done[1024];
  logic tr_rb[1024];
  int   n_rec;
  bit   timed_out;

  int         load_n, gap_n, unl_n, unl_ones, done_idx, low_in_bad, busy_bad;
  logic [7:0] load_bits;

  firebird7_in_gate2_occ_capture_seq dut (
    .slow_clock   (clk),
    .reset        (reset),
    .start        (start),
    .pattern      (pattern),
    .pattern_len  (pattern_len),
    .capture_wait (capture_wait),
    .occ_scan_out (occ_scan_out),
    .scan_en      (scan_en),
    .scan_in      (scan_in),
    .busy         (busy),
    .done         (done)
`ifdef FIREBIRD7_OCC_SEQ_READBACK_EN
    ,.readback_err (readback_err)
`endif
  );

`ifndef FIREBIRD7_OCC_SEQ_READBACK_EN
  assign readback_err = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic analyze();
    int k;
    k = 0;
    load_n = 0; gap_n = 0; unl_n = 0; unl_ones = 0;
    load_bits = '0; done_idx = -1; low_in_bad = 0; busy_bad = 0;
    while (k < n_rec && tr_en[k]) begin
      if (k < 8) load_bits = load_bits | (8'(tr_in[k]) << k);
      load_n++; k++;
    end
    while (k < n_rec && !tr_en[k]) begin
      gap_n++; k++;
    end
    while (k < n_rec && tr_en[k]) begin
      unl_n++;
      if (tr_in[k]) unl_ones++;
      k++;
    end
    for (int j = 0; j < n_rec; j++) begin
      if (!tr_en[j] && tr_in[j]) low_in_bad++;
      if (tr_done[j] && done_idx < 0) done_idx = j;
    end
    for (int j = 0; j < n_rec; j++)
      if (j < done_idx && !tr_busy[j]) busy_bad++;
  endtask

  // Index 0 is the cycle right after the accepting edge; returns in the
  // cycle after DONE. occ_scan_out is driven high only at index inj.
  task automatic do_run(input logic [4:0] p, input logic [2:0] l,
                        input logic [7:0] w, input int inj);
    pattern = p; pattern_len = l; capture_wait = w; start = 1'b1;
    tick();
    start = 1'b0; timed_out = 1'b1; n_rec = 0;
    for (int i = 0; i < 1000; i++) begin
      occ_scan_out = (i == inj);
      tr_en[i] = scan_en; tr_in[i] = scan_in;
      tr_busy[i] = busy; tr_done[i] = done; tr_rb[i] = readback_err;
      n_rec = i + 1;
      tick();
      if (tr_done[i]) begin
        timed_out = 1'b0;
        break;
      end
    end
    occ_scan_out = 1'b0;
    analyze();
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; pattern = '0; pattern_len = '0;
    capture_wait = '0; occ_scan_out = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({scan_en, scan_in, busy, done, readback_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {scan_en, scan_in, busy, done, readback_err});
    end
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({scan_en, busy, done} !== 3'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b want 000", {scan_en, busy, done});
    end
  endtask

  task automatic test_basic();
    do_run(5'b00101, 3'd2, 8'd3, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
    checks++;
    if (load_n != 3) begin errors++; $display("FAIL basic_load_n: got %0d want 3", load_n); end
    checks++;
    if (load_bits !== 8'b101) begin errors++; $display("FAIL basic_load_bits: got %b want 101", load_bits); end
    checks++;
    if (gap_n != 6) begin errors++; $display("FAIL basic_gap: got %0d want 6", gap_n); end
    checks++;
    if (unl_n != 3) begin errors++; $display("FAIL basic_unload_n: got %0d want 3", unl_n); end
    checks++;
    if (unl_ones != 0) begin errors++; $display("FAIL basic_unload_zero: got %0d ones want 0", unl_ones); end
    checks++;
    if (done_idx != 12) begin errors++; $display("FAIL basic_done_idx: got %0d want 12", done_idx); end
    checks++;
    if (busy_bad != 0 || tr_busy[12] !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: low_before_done=%0d busy_at_done=%b want 0 0", busy_bad, tr_busy[12]);
    end
    checks++;
    if (low_in_bad != 0) begin errors++; $display("FAIL basic_scan_in_low: got %0d want 0", low_in_bad); end
    checks++;
    if ({done, busy, scan_en} !== 3'b0) begin
      errors++;
      $display("FAIL basic_after_done: got %b want 000", {done, busy, scan_en});
    end
  endtask

  task automatic test_clamp();
    do_run(5'b11111, 3'd7, 8'd0, -1);
    checks++;
    if (load_n != 5) begin errors++; $display("FAIL clamp_load_n: got %0d want 5", load_n); end
    checks++;
    if (load_bits !== 8'h1f) begin errors++; $display("FAIL clamp_load_bits: got %b want 11111", load_bits); end
    checks++;
    if (unl_n != 5) begin errors++; $display("FAIL clamp_unload_n: got %0d want 5", unl_n); end
    checks++;
    if (gap_n != 3) begin errors++; $display("FAIL clamp_gap: got %0d want 3", gap_n); end
    checks++;
    if (done_idx != 13) begin errors++; $display("FAIL clamp_done_idx: got %0d want 13", done_idx); end
  endtask

  task automatic test_max_wait();
    do_run(5'b00010, 3'd1, 8'd255, -1);
    checks++;
    if (timed_out) begin errors++; $display("FAIL maxw_timeout: no done within budget"); end
    checks++;
    if (load_bits !== 8'b10 || load_n != 2) begin
      errors++;
      $display("FAIL maxw_load: got bits=%b n=%0d want 10 2", load_bits, load_n);
    end
    checks++;
    if (gap_n != 258) begin errors++; $display("FAIL maxw_gap: got %0d want 258", gap_n); end
    checks++;
    if (done_idx != 262) begin errors++; $display("FAIL maxw_done_idx: got %0d want 262", done_idx); end
  endtask

  task automatic test_back_to_back();
    int n_done, n_low;
    pattern = 5'b00011; pattern_len = 3'd0; capture_wait = 8'd0;
    start = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      tr_en[i] = scan_en; tr_in[i] = scan_in;
      tr_busy[i] = busy; tr_done[i] = done;
      tick();
    end
    start = 1'b0;
    n_done = 0; n_low = 0;
    for (int i = 0; i < 20; i++) begin
      if (tr_done[i]) n_done++;
      if (!tr_busy[i]) n_low++;
    end
    checks++;
    if (n_done != 3) begin errors++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    checks++;
    if ({tr_done[5], tr_done[12], tr_done[19]} !== 3'b111) begin
      errors++;
      $display("FAIL b2b_done_pos: got %b want 111", {tr_done[5], tr_done[12], tr_done[19]});
    end
    checks++;
    if ({tr_en[6], tr_en[7], tr_in[7]} !== 3'b011) begin
      errors++;
      $display("FAIL b2b_restart: got %b want 011", {tr_en[6], tr_en[7], tr_in[7]});
    end
    checks++;
    if (n_low != 5) begin errors++; $display("FAIL b2b_busy_low: got %0d want 5", n_low); end
    tick();
    checks++;
    if ({busy, scan_en, done} !== 3'b0) begin
      errors++;
      $display("FAIL b2b_idle: got %b want 000", {busy, scan_en, done});
    end
  endtask

  task automatic test_reset_mid();
    int n_done, n_busy;
    pattern = 5'b00001; pattern_len = 3'd1; capture_wait = 8'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({busy, scan_en} !== 2'b10) begin
      errors++;
      $display("FAIL mid_in_capture: got %b want 10", {busy, scan_en});
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({scan_en, scan_in, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL mid_reset_out: got %b want 0000", {scan_en, scan_in, busy, done});
    end
    reset = 1'b1;
    n_done = 0; n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) n_done++;
      if (busy) n_busy++;
    end
    checks++;
    if (n_done != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL mid_no_done: got done=%0d busy=%0d want 0 0", n_done, n_busy);
    end
    do_run(5'b00001, 3'd0, 8'd1, -1);
    checks++;
    if (done_idx != 6 || load_n != 1 || load_bits !== 8'b1) begin
      errors++;
      $display("FAIL mid_rerun: got done=%0d n=%0d bits=%b want 6 1 1", done_idx, load_n, load_bits);
    end
  endtask

`ifdef FIREBIRD7_OCC_SEQ_READBACK_EN
  task automatic test_readback();
    checks++;
    if (readback_err !== 1'b0) begin
      errors++;
      $display("FAIL rb_clean: got %b want 0", readback_err);
    end
    do_run(5'b00011, 3'd1, 8'd0, 5);
    checks++;
    if ({tr_rb[4], tr_rb[6]} !== 2'b01) begin
      errors++;
      $display("FAIL rb_set: got %b want 01", {tr_rb[4], tr_rb[6]});
    end
    tick(); tick(); tick();
    checks++;
    if (readback_err !== 1'b1) begin
      errors++;
      $display("FAIL rb_sticky: got %b want 1", readback_err);
    end
    do_run(5'b00011, 3'd1, 8'd0, -1);
    checks++;
    if (tr_rb[0] !== 1'b0 || readback_err !== 1'b0) begin
      errors++;
      $display("FAIL rb_clear: got %b%b want 00", tr_rb[0], readback_err);
    end
    do_run(5'b00011, 3'd1, 8'd0, 7);
    checks++;
    if (readback_err !== 1'b1) begin
      errors++;
      $display("FAIL rb_done_sample: got %b want 1", readback_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_max_wait();
    test_back_to_back();
    test_reset_mid();
`ifdef FIREBIRD7_OCC_SEQ_READBACK_EN
    test_readback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
